// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter
//   Shares one 16-bit SPI transmit serializer among NREQ host-side requesters.
//   Round-robin grant, one-cycle launch pulse, completion wait guarded by a
//   watchdog that aborts a hung serializer, and a forced idle gap between frames.
//   Frame sequence: IDLE -> LAUNCH -> WAIT -> GAP -> IDLE.
//
//   Build option SPI_ARB_PRIO0_EN: requester 0 becomes strict high priority and
//   requesters 1..NREQ-1 round-robin among themselves. A grant to requester 0
//   leaves the round-robin pointer untouched. Without the macro, pure
//   round-robin runs over all NREQ requesters.
module spi_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int DW         = 16,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 eng_start,
  output logic [DW-1:0]        eng_data,
  output logic                 eng_abort,
  input  logic                 eng_done,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 frame_done,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_GAP    = 2'd3
  } state_e;

  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  // The watchdog is cleared in LAUNCH and counts 0,1,2.. through WAIT. When the
  // incremented value would reach TIMEOUT-1, the abort is registered. The
  // abort pulse then lands exactly TIMEOUT cycles after eng_start.
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 2);

  // GAP starts in the cycle that carries frame_done/timeout_err. GAP_CYCLES
  // further idle cycles follow that end-of-frame cycle before IDLE.
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES);
  localparam state_e POST_FRAME = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]   eng_data_q, eng_data_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic [GCW-1:0]  gap_cnt_q, gap_cnt_d;
  logic            frame_done_q, frame_done_d;
  logic            abort_q, abort_d;

  logic            arb_found;
  logic [IDW-1:0]  arb_idx;
  logic [DW-1:0]   arb_data;
  logic            arb_upd_ptr;
  logic            accept;

  // Requester index k positions after the pointer, wrapped into 0..NREQ-1.
  function automatic int rr_index(input logic [IDW-1:0] ptr, input int k);
    int j;
    j = int'(ptr) + k;
    if (j >= NREQ) j = j - NREQ;
    return j;
  endfunction

  // Arbitration: pick the first valid requester after rr_ptr; the accept is
  // combinational on req_valid so ready appears in the same cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned; this is what keeps combinational blocks free of latches.
    arb_found   = 1'b0;
    arb_idx     = '0;
    arb_data    = '0;
    arb_upd_ptr = 1'b1;
    for (int k = 1; k <= NREQ; k++) begin
      if (!arb_found && req_valid[rr_index(rr_ptr_q, k)]) begin
        arb_found = 1'b1;
        arb_idx   = IDW'(rr_index(rr_ptr_q, k));
        arb_data  = req_data[rr_index(rr_ptr_q, k)*DW +: DW];
      end
    end
`ifdef SPI_ARB_PRIO0_EN
    if (req_valid[0]) begin
      arb_found   = 1'b1;
      arb_idx     = '0;
      arb_data    = req_data[DW-1:0];
      arb_upd_ptr = 1'b0;
    end
`endif
    accept = arb_found && (state_q == S_IDLE) && !reset;
  end

  // Next-state and datapath: frame sequencing, watchdog, gap counter and the
  // registered end-of-frame pulses.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    eng_data_d   = eng_data_q;
    grant_id_d   = grant_id_q;
    wdog_d       = wdog_q;
    gap_cnt_d    = gap_cnt_q;
    frame_done_d = 1'b0;
    abort_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_LAUNCH;
          eng_data_d = arb_data;
          grant_id_d = arb_idx;
          if (arb_upd_ptr) rr_ptr_d = arb_idx;
        end
      end
      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // Completion is checked first, so a done on the threshold cycle wins.
        if (eng_done) begin
          frame_done_d = 1'b1;
          gap_cnt_d    = '0;
          state_d      = POST_FRAME;
        end else if (wdog_q == WDOG_LAST) begin
          abort_d   = 1'b1;
          gap_cnt_d = '0;
          state_d   = POST_FRAME;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: only control and the held word are reset; there is no storage array here that would need clearing.
      state_q      <= S_IDLE;
      rr_ptr_q     <= IDW'(NREQ - 1);
      eng_data_q   <= '0;
      grant_id_q   <= '0;
      wdog_q       <= '0;
      gap_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      eng_data_q   <= eng_data_d;
      grant_id_q   <= grant_id_d;
      wdog_q       <= wdog_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_done_q <= frame_done_d;
      abort_q      <= abort_d;
    end
  end

  // Outputs: decoded from state plus the one-hot accept strobe.
  always_comb begin
    busy        = (state_q != S_IDLE);
    eng_start   = (state_q == S_LAUNCH);
    eng_data    = eng_data_q;
    grant_id    = grant_id_q;
    frame_done  = frame_done_q;
    timeout_err = abort_q;
    eng_abort   = abort_q;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (arb_idx == IDW'(i));
    end
  end

endmodule
